// File: rtl/serial_word_receiver.sv
// LSB-first serial-to-parallel word receiver with valid/ready output and sticky overrun.
// Optional parity bit per frame when SWR_PARITY_EN is defined.
module serial_word_receiver #(
  parameter int WIDTH       = 4,
  parameter int EVEN_PARITY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_start,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
`ifdef SWR_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SWR_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             deliver;
  logic             slot_free;

`ifdef SWR_PARITY_EN
  logic parity_err_q, parity_err_d;
  logic par_bad;
`else
  logic unused_bits;
  assign unused_bits = shift_q[0] ^ (EVEN_PARITY != 0);
`endif

  assign shifted   = {sin_bit, shift_q[WIDTH-1:1]};
  assign slot_free = !dout_valid_q || dout_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SWR_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
`ifdef SWR_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    word         = shift_q;
    deliver      = 1'b0;
`ifdef SWR_PARITY_EN
    parity_err_d = parity_err_q;
    par_bad      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (sin_start) begin
          state_d = SHIFT;
          count_d = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        // A start strobe restarts the frame and discards any same-cycle bit.
        if (sin_start) begin
          count_d = '0;
          shift_d = '0;
        end else if (sin_valid) begin
          shift_d = shifted;
          if (count_q == LAST) begin
            count_d = '0;
`ifdef SWR_PARITY_EN
            state_d = PARITY;
`else
            word    = shifted;
            deliver = 1'b1;
            state_d = IDLE;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
`ifdef SWR_PARITY_EN
      PARITY: begin
        if (sin_start) begin
          state_d = SHIFT;
          count_d = '0;
          shift_d = '0;
        end else if (sin_valid) begin
          word    = shift_q;
          deliver = 1'b1;
          par_bad = ((^shift_q) ^ sin_bit) != (EVEN_PARITY == 0);
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (overrun_clr) overrun_d = 1'b0;

    if (deliver && slot_free) begin
      dout_d       = word;
      dout_valid_d = 1'b1;
`ifdef SWR_PARITY_EN
      parity_err_d = par_bad;
`endif
    end else if (deliver) begin
      overrun_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;
`ifdef SWR_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
